// File: rtl/uart_cmd_ctrl_pkg.sv
// Shared constants, state encoding and sizing helper for the UART command frame controller.
package uart_cmd_ctrl_pkg;

  localparam logic [7:0] SOF_BYTE_DEF = 8'hA5;
  localparam logic [7:0] CMD_WRITE    = 8'h01;
  localparam logic [7:0] CMD_BAUD     = 8'h02;

  localparam logic [1:0] ERR_CHK = 2'd0;
  localparam logic [1:0] ERR_TMO = 2'd1;
  localparam logic [1:0] ERR_CMD = 2'd2;
  localparam logic [1:0] ERR_OVR = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CMD     = 3'd1,
    ST_ADDR    = 3'd2,
    ST_LEN     = 3'd3,
    ST_PAYLOAD = 3'd4,
    ST_CHK     = 3'd5,
    ST_DRAIN   = 3'd6,
    ST_BAUD    = 3'd7
  } state_e;

  // Bits needed to count n distinct values, never less than one.
  function automatic int clogb2(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((32'sd1 <<< i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/uart_cmd_ctrl_if.sv
// Receive-byte handshake and register-write bus of the command controller.
interface uart_cmd_ctrl_if;
  logic       rx_valid_i;
  logic [7:0] rx_data_i;
  logic       wr_en_o;
  logic [7:0] wr_addr_o;
  logic [7:0] wr_data_o;

  modport master (input rx_valid_i, rx_data_i, output wr_en_o, wr_addr_o, wr_data_o);
  modport slave  (output rx_valid_i, rx_data_i, input wr_en_o, wr_addr_o, wr_data_o);
endinterface

// File: rtl/uart_cmd_ctrl_buf.sv
// Payload buffer: simple dual-port RAM with synchronous write and registered read.
module uart_cmd_buf #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata_o
);

  logic [7:0] mem_q [DEPTH];
  logic [7:0] rdata_q;

  // Storage array; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  // Read register only moves on a read, so it holds between reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  rdata_q <= 8'd0;
    else if (re) rdata_q <= mem_q[raddr];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/uart_cmd_ctrl.sv
// Frame parser/sequencer behind uart_rx: validates SOF/CMD/ADDR/LEN/payload/CHK frames,
// then issues register writes or reprograms the receiver baud select.
module uart_cmd_ctrl
  import uart_cmd_ctrl_pkg::*;
#(
  parameter int unsigned UART_CLK_MHZ = 50,
  parameter logic [7:0]  SOF_BYTE     = SOF_BYTE_DEF,
  parameter int unsigned MAX_LEN      = 16,
  parameter int unsigned TIMEOUT_CYC  = UART_CLK_MHZ * 1000,
  parameter logic [2:0]  BAUD_RST     = 3'd4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  uart_cmd_ctrl_if.master       bus,
  output logic [2:0]            baud_sel_o,
  output logic                  busy_o,
  output logic                  frame_done_o,
  output logic                  frame_err_o,
  output logic [1:0]            err_code_o
);

  localparam int IDXW = clogb2(int'(MAX_LEN));
  localparam int TMOW = clogb2(int'(TIMEOUT_CYC));

  state_e            state_q, state_d;
  logic [7:0]        cmd_q, cmd_d, addr_q, addr_d, len_q, len_d, chk_q, chk_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic              last_q, last_d, ovr_q, ovr_d;
  logic [TMOW-1:0]   tmo_q, tmo_d;
  logic [2:0]        baud_nxt_q, baud_nxt_d, baud_sel_q, baud_sel_d;
  logic              wr_en_q, wr_en_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic [7:0]        wr_addr_q, wr_addr_d;
  logic [1:0]        err_code_q, err_code_d;

  logic              rx_valid_s, in_frame_s, tmo_hit_s, idx_last_s, len_ok_s;
  logic              buf_we_s, buf_re_s;
  logic [7:0]        rx_data_s, buf_rdata_s;

  assign rx_valid_s = bus.rx_valid_i;
  assign rx_data_s  = bus.rx_data_i;
  assign in_frame_s = state_q inside {ST_CMD, ST_ADDR, ST_LEN, ST_PAYLOAD, ST_CHK};
  assign tmo_hit_s  = (tmo_q == TMOW'(TIMEOUT_CYC - 32'd1));
  assign idx_last_s = (8'(idx_q) == (len_q - 8'd1));
  assign len_ok_s   = ((cmd_q == CMD_WRITE) && (rx_data_s != 8'd0) &&
                       ({1'b0, rx_data_s} <= 9'(MAX_LEN))) ||
                      ((cmd_q == CMD_BAUD) && (rx_data_s == 8'd1));

  uart_cmd_buf #(.DEPTH(int'(MAX_LEN)), .AW(IDXW)) u_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (buf_we_s),
    .waddr   (idx_q),
    .wdata   (rx_data_s),
    .re      (buf_re_s),
    .raddr   (idx_q),
    .rdata_o (buf_rdata_s)
  );

  // Next-state and next-output logic of the frame sequencer.
  always_comb begin
    state_d    = state_q;    cmd_d      = cmd_q;      addr_d    = addr_q;
    len_d      = len_q;      chk_d      = chk_q;      idx_d     = idx_q;
    last_d     = last_q;     ovr_d      = ovr_q;      baud_nxt_d = baud_nxt_q;
    baud_sel_d = baud_sel_q; wr_addr_d  = wr_addr_q;  err_code_d = err_code_q;
    wr_en_d    = 1'b0;       done_d     = 1'b0;       err_d     = 1'b0;
    buf_we_s   = 1'b0;       buf_re_s   = 1'b0;
    if (in_frame_s && !rx_valid_s) tmo_d = tmo_q + TMOW'(1);
    else                           tmo_d = {TMOW{1'b0}};

    if (in_frame_s && tmo_hit_s) begin
      // Timeout wins over a byte landing in the same cycle; that byte is dropped.
      state_d = ST_IDLE; err_d = 1'b1; err_code_d = ERR_TMO; tmo_d = {TMOW{1'b0}};
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (rx_valid_s && (rx_data_s == SOF_BYTE)) begin state_d = ST_CMD; ovr_d = 1'b0; end
          else state_d = ST_IDLE;
        end
        ST_CMD: begin
          if (rx_valid_s) begin cmd_d = rx_data_s; chk_d = rx_data_s; state_d = ST_ADDR; end
          else state_d = ST_CMD;
        end
        ST_ADDR: begin
          if (rx_valid_s) begin addr_d = rx_data_s; chk_d = chk_q ^ rx_data_s; state_d = ST_LEN; end
          else state_d = ST_ADDR;
        end
        ST_LEN: begin
          if (rx_valid_s) begin
            len_d = rx_data_s; chk_d = chk_q ^ rx_data_s; idx_d = {IDXW{1'b0}};
            if (len_ok_s) state_d = ST_PAYLOAD;
            else begin state_d = ST_IDLE; err_d = 1'b1; err_code_d = ERR_CMD; end
          end else state_d = ST_LEN;
        end
        ST_PAYLOAD: begin
          if (rx_valid_s) begin
            buf_we_s = 1'b1; chk_d = chk_q ^ rx_data_s;
            if (idx_q == {IDXW{1'b0}}) baud_nxt_d = rx_data_s[2:0];
            else                        baud_nxt_d = baud_nxt_q;
            if (idx_last_s) state_d = ST_CHK;
            else            idx_d = idx_q + IDXW'(1);
          end else state_d = ST_PAYLOAD;
        end
        ST_CHK: begin
          if (rx_valid_s) begin
            idx_d = {IDXW{1'b0}}; last_d = 1'b0;
            if (rx_data_s != chk_q) begin state_d = ST_IDLE; err_d = 1'b1; err_code_d = ERR_CHK; end
            else if (cmd_q == CMD_WRITE) state_d = ST_DRAIN;
            else state_d = ST_BAUD;
          end else state_d = ST_CHK;
        end
        ST_DRAIN: begin
          if (rx_valid_s) ovr_d = 1'b1;
          else            ovr_d = ovr_q;
          // Read issued this cycle; wr_en/addr registered to line up with the RAM read data.
          if (!last_q) begin
            buf_re_s = 1'b1; wr_en_d = 1'b1; wr_addr_d = addr_q + 8'(idx_q);
            if (idx_last_s) last_d = 1'b1;
            else            idx_d = idx_q + IDXW'(1);
          end else begin
            state_d = ST_IDLE;
            if (ovr_q || rx_valid_s) begin err_d = 1'b1; err_code_d = ERR_OVR; end
            else done_d = 1'b1;
          end
        end
        ST_BAUD: begin
          baud_sel_d = baud_nxt_q; state_d = ST_IDLE;
          if (rx_valid_s) begin err_d = 1'b1; err_code_d = ERR_OVR; end
          else done_d = 1'b1;
        end
        default: state_d = ST_IDLE;
      endcase
    end
    busy_d = (state_d != ST_IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;  cmd_q <= 8'd0;  addr_q <= 8'd0;  len_q <= 8'd0;  chk_q <= 8'd0;
      idx_q <= {IDXW{1'b0}}; last_q <= 1'b0; ovr_q <= 1'b0; tmo_q <= {TMOW{1'b0}};
      baud_nxt_q <= 3'd0;  baud_sel_q <= BAUD_RST;  wr_en_q <= 1'b0;  wr_addr_q <= 8'd0;
      busy_q <= 1'b0;  done_q <= 1'b0;  err_q <= 1'b0;  err_code_q <= 2'd0;
    end else begin
      state_q <= state_d;  cmd_q <= cmd_d;  addr_q <= addr_d;  len_q <= len_d;  chk_q <= chk_d;
      idx_q <= idx_d;  last_q <= last_d;  ovr_q <= ovr_d;  tmo_q <= tmo_d;
      baud_nxt_q <= baud_nxt_d;  baud_sel_q <= baud_sel_d;  wr_en_q <= wr_en_d;  wr_addr_q <= wr_addr_d;
      busy_q <= busy_d;  done_q <= done_d;  err_q <= err_d;  err_code_q <= err_code_d;
    end
  end

  assign bus.wr_en_o   = wr_en_q;
  assign bus.wr_addr_o = wr_addr_q;
  assign bus.wr_data_o = buf_rdata_s;
  assign baud_sel_o    = baud_sel_q;
  assign busy_o        = busy_q;
  assign frame_done_o  = done_q;
  assign frame_err_o   = err_q;
  assign err_code_o    = err_code_q;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Randomised self-checking bench for uart_cmd_ctrl against a frame-level reference model.
module tb_uart_cmd_ctrl;

  localparam int CLK_MHZ = 1;
  localparam int TMO     = CLK_MHZ * 1000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] baud_sel;
  logic       busy, frame_done, frame_err;
  logic [1:0] err_code;

  uart_cmd_ctrl_if bus ();

  uart_cmd_ctrl #(.UART_CLK_MHZ(CLK_MHZ)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .baud_sel_o   (baud_sel),
    .busy_o       (busy),
    .frame_done_o (frame_done),
    .frame_err_o  (frame_err),
    .err_code_o   (err_code)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [15:0] wq[$];      // observed writes {addr, data}
  logic [15:0] ew[$];      // expected writes
  logic [7:0]  fr[$];      // frame under test
  logic [7:0]  pl[$];      // payload for build
  int          exp_res;    // 0 done, 1 error
  logic [1:0]  exp_code;
  logic [2:0]  exp_baud;

  always @(negedge clk) begin
    if (rst_n && bus.wr_en_o) wq.push_back({bus.wr_addr_o, bus.wr_data_o});
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Frame-level reference: what a frame of which nsend bytes were sent should produce.
  task automatic model(input int nsend, input bit ovr);
    logic [7:0] cmd, addr, x, a;
    int len;
    ew.delete(); exp_res = 0; exp_code = 2'd0;
    if (nsend < 4) begin exp_res = 1; exp_code = 2'd1; return; end
    cmd = fr[1]; addr = fr[2]; len = int'(fr[3]);
    if (!((cmd == 8'h01 && len >= 1 && len <= 16) || (cmd == 8'h02 && len == 1))) begin
      exp_res = 1; exp_code = 2'd2; return;
    end
    if (nsend < len + 5) begin exp_res = 1; exp_code = 2'd1; return; end
    x = 8'd0;
    for (int i = 1; i <= len + 3; i++) x ^= fr[i];
    if (x != fr[len + 4]) begin exp_res = 1; exp_code = 2'd0; return; end
    if (cmd == 8'h01) begin
      for (int i = 0; i < len; i++) begin
        a = addr + 8'(i);
        ew.push_back({a, fr[4 + i]});
      end
    end else exp_baud = fr[4][2:0];
    if (ovr) begin exp_res = 1; exp_code = 2'd3; end
  endtask

  task automatic build(input logic [7:0] cmd, input logic [7:0] addr, input logic [7:0] len,
                       input logic [7:0] flip);
    logic [7:0] x;
    fr = {8'hA5, cmd, addr, len};
    x = cmd ^ addr ^ len;
    foreach (pl[i]) begin fr.push_back(pl[i]); x ^= pl[i]; end
    fr.push_back(x ^ flip);
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.rx_valid_i = 1'b1; bus.rx_data_i = b;
    @(negedge clk);
    bus.rx_valid_i = 1'b0;
  endtask

  task automatic run_frame(input int nsend, input bit ovr, input int wait_max);
    int got, k;
    logic [1:0] code;
    model(nsend, ovr);
    wq.delete();
    for (int i = 0; i < nsend; i++) begin
      send_byte(fr[i]);
      if (i == 0) check_val("busy_in_frame", 32'(busy), 32'd1);
      if (i != nsend - 1) repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    if (ovr) begin
      if (fr[1] == 8'h01) @(negedge clk);
      send_byte(8'h5A);
    end
    got = 2; k = 0; code = 2'd0;
    while (k < wait_max) begin
      if (frame_done || frame_err) begin
        check_val("done_err_excl", 32'(frame_done & frame_err), 32'd0);
        got = frame_err ? 1 : 0; code = err_code;
        break;
      end
      @(negedge clk); k++;
    end
    check_val("result", got, exp_res);
    if (got == 1 && exp_res == 1) check_val("err_code", 32'(code), 32'(exp_code));
    if (got == 1 && exp_code == 2'd1) check_val("tmo_latency", 32'(k >= TMO - 2 && k <= TMO + 2), 32'd1);
    @(negedge clk);
    check_val("pulse_one_cycle", 32'(frame_done | frame_err), 32'd0);
    check_val("busy_after", 32'(busy), 32'd0);
    check_val("baud_sel", 32'(baud_sel), 32'(exp_baud));
    check_val("wr_count", wq.size(), ew.size());
    for (int i = 0; i < ew.size() && i < wq.size(); i++) check_val("wr_addr_data", 32'(wq[i]), 32'(ew[i]));
    repeat (2) @(negedge clk);
  endtask

  task automatic rand_payload(input int n);
    pl.delete();
    for (int i = 0; i < n; i++) pl.push_back(8'($urandom_range(0, 255)));
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    int r, ln;
    logic [7:0] c;
    bus.rx_valid_i = 1'b0; bus.rx_data_i = 8'd0; exp_baud = 3'd4;
    repeat (3) @(negedge clk);
    check_val("rst_baud", 32'(baud_sel), 32'd4);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_wr_en", 32'(bus.wr_en_o), 32'd0);
    check_val("rst_done", 32'(frame_done), 32'd0);
    check_val("rst_err", 32'(frame_err), 32'd0);
    check_val("rst_code", 32'(err_code), 32'd0);
    check_val("rst_wr_addr", 32'(bus.wr_addr_o), 32'd0);
    check_val("rst_wr_data", 32'(bus.wr_data_o), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    pl = {8'h11, 8'h22, 8'h33}; build(8'h01, 8'h10, 8'h03, 8'h00); run_frame(fr.size(), 1'b0, 200);
    pl = {8'hAA, 8'hBB, 8'hCC}; build(8'h01, 8'hFE, 8'h03, 8'h00); run_frame(fr.size(), 1'b0, 200);
    pl = {8'h06};               build(8'h02, 8'h00, 8'h01, 8'h00); run_frame(fr.size(), 1'b0, 200);
    pl = {8'h11, 8'h22, 8'h33}; build(8'h01, 8'h10, 8'h03, 8'h00); run_frame(fr.size(), 1'b0, 200);
    pl = {8'h11, 8'h22, 8'h33}; build(8'h01, 8'h10, 8'h03, 8'h01); run_frame(fr.size(), 1'b0, 200);
    build(8'h01, 8'h10, 8'h00, 8'h00); run_frame(3, 1'b0, TMO + 50);
    build(8'h01, 8'h10, 8'h00, 8'h00); run_frame(4, 1'b0, 200);
    build(8'h07, 8'h10, 8'h01, 8'h00); run_frame(4, 1'b0, 200);
    build(8'h02, 8'h10, 8'h02, 8'h00); run_frame(4, 1'b0, 200);
    build(8'h01, 8'h10, 8'h11, 8'h00); run_frame(4, 1'b0, 200);
    rand_payload(5); build(8'h01, 8'h40, 8'h05, 8'h00); run_frame(fr.size() - 1, 1'b0, TMO + 50);
    pl = {8'h11, 8'h22, 8'h33}; build(8'h01, 8'h10, 8'h03, 8'h00); run_frame(fr.size(), 1'b1, 200);
    pl = {8'h03};               build(8'h02, 8'h00, 8'h01, 8'h00); run_frame(fr.size(), 1'b1, 200);
    rand_payload(16); build(8'h01, 8'hF8, 8'h10, 8'h00); run_frame(fr.size(), 1'b0, 200);
    pl = {8'h5C};               build(8'h01, 8'h00, 8'h01, 8'h00); run_frame(fr.size(), 1'b1, 200);

    for (int it = 0; it < 40; it++) begin
      r = int'($urandom_range(0, 9));
      ln = int'($urandom_range(1, 16));
      if (r <= 5 || r == 9) begin
        rand_payload(ln); build(8'h01, 8'($urandom_range(0, 255)), 8'(ln), 8'h00);
        run_frame(fr.size(), r == 9, 200);
      end else if (r == 6) begin
        rand_payload(1); build(8'h02, 8'($urandom_range(0, 255)), 8'h01, 8'h00);
        run_frame(fr.size(), 1'b0, 200);
      end else if (r == 7) begin
        rand_payload(ln); build(8'h01, 8'($urandom_range(0, 255)), 8'(ln), 8'(1 << $urandom_range(0, 7)));
        run_frame(fr.size(), 1'b0, 200);
      end else begin
        pl.delete();
        case ($urandom_range(0, 2))
          0: build(8'h01, 8'h20, 8'h00, 8'h00);
          1: build(8'h01, 8'h20, 8'($urandom_range(17, 255)), 8'h00);
          default: begin
            c = 8'($urandom_range(0, 255));
            if (c == 8'h01 || c == 8'h02) c = 8'h33;
            build(c, 8'h20, 8'($urandom_range(0, 255)), 8'h00);
          end
        endcase
        run_frame(4, 1'b0, 200);
      end
    end

    // Reset in the middle of the payload: no writes afterwards, baud back to reset value.
    rand_payload(4); build(8'h01, 8'h10, 8'h04, 8'h00);
    for (int i = 0; i < 6; i++) send_byte(fr[i]);
    rst_n = 1'b0; exp_baud = 3'd4;
    @(negedge clk);
    check_val("rst_mid_busy", 32'(busy), 32'd0);
    check_val("rst_mid_baud", 32'(baud_sel), 32'd4);
    rst_n = 1'b1; wq.delete();
    repeat (30) @(negedge clk);
    check_val("rst_mid_writes", wq.size(), 0);

    // Reset in the middle of the write drain.
    rand_payload(12); build(8'h01, 8'h80, 8'h0C, 8'h00);
    for (int i = 0; i < fr.size(); i++) send_byte(fr[i]);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_val("rst_drain_wr_en", 32'(bus.wr_en_o), 32'd0);
    rst_n = 1'b1; wq.delete();
    repeat (30) @(negedge clk);
    check_val("rst_drain_writes", wq.size(), 0);

    pl = {8'h11, 8'h22, 8'h33}; build(8'h01, 8'h10, 8'h03, 8'h00); run_frame(fr.size(), 1'b0, 200);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
